fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the 16-bit pipelined processor; sits directly upstream of the decode stage. It owns the program counter and drives a synchronous instruction memory (one-cycle read latency). It delivers the instruction and its PC through the IF/ID pipeline register to the decoder. A one-entry hold buffer absorbs the in-flight read when decode stalls, and taken-branch/jump redirects flush the stage.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; PC width.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; IF/ID must hold its contents.
- redirect_valid  in  1  flush the stage and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect target word address.
- imem_addr  out  ADDR_WIDTH  read address to instruction memory; equals pc_q.
- imem_rdata  in  16  instruction for the address presented in the previous cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  16  instruction to decode; NOP (16'hA000, opcode 101) when not valid.
- if_id_pc  out  ADDR_WIDTH  PC of if_id_inst.

## Operation
- Internal state:
  - pc_q: next address to issue.
  - req_valid_q / req_pc_q: a read issued last cycle whose data is on imem_rdata now.
  - hold_valid_q / hold_inst_q / hold_pc_q: skid entry.
  - IF/ID register.
- Priority per cycle: rst > redirect_valid > stall > normal.
- Reset:
  - pc_q=RESET_PC; req_valid_q=0; hold_valid_q=0.
  - if_id_valid=0, if_id_inst=16'hA000, if_id_pc=0.
- Redirect (overrides stall):
  - IF/ID loads a bubble (valid=0, inst=16'hA000).
  - req_valid_q and hold_valid_q are cleared, discarding wrong-path data.
  - pc_q=redirect_pc.
- Stall, no redirect:
  - IF/ID unchanged; pc_q unchanged.
  - If req_valid_q, capture imem_rdata/req_pc_q into the hold entry and set hold_valid_q.
  - req_valid_q←0; no new request counts as issued.
- Normal:
  - IF/ID loads the hold entry if hold_valid_q; otherwise imem_rdata/req_pc_q if req_valid_q; otherwise a bubble.
  - hold_valid_q←0; req_valid_q←1; req_pc_q←pc_q.
  - pc_q←pc_q+1, wrapping modulo 2^ADDR_WIDTH (no overflow flag).
- Invariant: hold_valid_q and req_valid_q are never both 1. The bench asserts this.
- Derived states, reported for coverage:
  - EMPTY (neither valid): after reset or redirect.
  - STREAM (req_valid_q).
  - HOLD (hold_valid_q).
- Transitions:
  - EMPTY → STREAM on a normal cycle.
  - STREAM → HOLD on stall.
  - HOLD → STREAM on a normal cycle.
  - HOLD → HOLD on stall.
  - any → EMPTY on redirect or rst.
  - EMPTY on stall stays EMPTY.
- Decoder interprets only bits [15:13]. This stage never alters instruction bits other than substituting the NOP encoding for bubbles.

## Timing
- imem_addr = pc_q, combinational from the register.
- Reset released before edge t0:
  - RESET_PC is presented during cycle t0.
  - IF/ID shows valid RESET_PC after edge t1, i.e. 2-cycle fill latency.
- Steady state: one instruction per cycle, consecutive PCs.
- Redirect sampled at edge t:
  - Target presented on imem_addr after t.
  - IF/ID valid with the target after edge t+2; two bubbles in between.
- Stall asserted for N cycles then released:
  - IF/ID frozen for N cycles.
  - Next instruction appears the cycle after release, with no bubble and no duplicate or lost PC.
- Redirect and stall in the same cycle: redirect wins; IF/ID becomes a bubble despite stall.

## Structure
- Shared package:
  - INST_WIDTH=16.
  - NOP_INST=16'hA000.
  - Opcode field [15:13] and opcode constants (LDM 001, STD 010, ADD 011, NOT 100, NOP 101), also used by decode.
- One sub-module: if_id_register, holding valid/inst/pc with load, bubble and hold controls.
- PC, request tracking and hold buffer stay in fetch_stage.

## Test plan
Memory image: imem[0..5]=2400, 2802, A000, 6500, 8400, 4500.
- Reset then free-run → IF/ID invalid for the first cycle, then (pc, inst) = (0,2400), (1,2802), (2,A000), (3,6500), (4,8400), (5,4500), one per cycle.
- Stall for 3 cycles while IF/ID holds pc 1 → IF/ID stays (1,2802) for 3 cycles; after release shows (2,A000), (3,6500) with no gap or repeat.
- redirect_valid with redirect_pc=4 while IF/ID holds pc 1 → two bubbles with inst=A000 and valid=0, then (4,8400), (5,4500).
- Redirect to 3 and stall asserted together in HOLD state → hold entry discarded; bubble; then (3,6500).
- rst asserted mid-stream during a stall → next cycle if_id_valid=0, imem_addr=0; sequence restarts at (0,2400).
- ADDR_WIDTH=3, redirect to 7 → (7,x) followed by (0,2400), showing PC wrap-around.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the 16-bit pipeline front end: instruction width,
// opcode field location and encodings, and the NOP used for pipeline bubbles.
package fetch_stage_pkg;

    localparam int INST_WIDTH = 16;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 16'hA000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;

    typedef enum logic [2:0] {
        OPC_LDM = 3'b001,
        OPC_STD = 3'b010,
        OPC_ADD = 3'b011,
        OPC_NOT = 3'b100,
        OPC_NOP = 3'b101
    } opcode_e;

    // Occupancy of the fetch stage as seen from outside (req/hold valid bits)
    typedef enum logic [1:0] {
        FS_EMPTY  = 2'd0,
        FS_STREAM = 2'd1,
        FS_HOLD   = 2'd2
    } fetch_state_e;

    function automatic opcode_e get_opcode(input logic [INST_WIDTH-1:0] inst);
        return opcode_e'(inst[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: valid/instruction/PC with bubble, load and hold.
// Bubble takes priority over load; with neither asserted the contents hold.
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_bubble,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= '0;
        end else if (i_bubble) begin
            // PC is left as-is; it is meaningless while valid is low
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, tracks the one-cycle-latency memory read and
// parks it in a single skid entry while decode stalls. Redirects flush both.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  if_id_valid,
    output logic [INST_WIDTH-1:0] if_id_inst,
    output logic [ADDR_WIDTH-1:0] if_id_pc
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_req_valid;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic                  r_hold_valid;
    logic [INST_WIDTH-1:0] r_hold_inst;
    logic [ADDR_WIDTH-1:0] r_hold_pc;

    logic                  w_normal;
    logic                  w_ifid_load;
    logic                  w_ifid_bubble;
    logic [INST_WIDTH-1:0] w_ifid_inst;
    logic [ADDR_WIDTH-1:0] w_ifid_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_valid  <= 1'b0;
            r_req_pc     <= '0;
            r_hold_valid <= 1'b0;
            r_hold_inst  <= NOP_INST;
            r_hold_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc         <= redirect_pc;
            r_req_valid  <= 1'b0;
            r_hold_valid <= 1'b0;
        end else if (stall) begin
            // Data for the in-flight read arrives now and would be lost otherwise
            if (r_req_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_inst  <= imem_rdata;
                r_hold_pc    <= r_req_pc;
            end
            r_req_valid <= 1'b0;
        end else begin
            r_hold_valid <= 1'b0;
            r_req_valid  <= 1'b1;
            r_req_pc     <= r_pc;
            r_pc         <= r_pc + ADDR_WIDTH'(1);
        end
    end

    // Skid entry is older than any live read, so it is delivered first
    assign w_normal      = !redirect_valid && !stall;
    assign w_ifid_load   = w_normal && (r_hold_valid || r_req_valid);
    assign w_ifid_bubble = redirect_valid || (w_normal && !r_hold_valid && !r_req_valid);
    assign w_ifid_inst   = r_hold_valid ? r_hold_inst : imem_rdata;
    assign w_ifid_pc     = r_hold_valid ? r_hold_pc   : r_req_pc;

    if_id_register #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ifid_load),
        .i_bubble(w_ifid_bubble),
        .i_inst  (w_ifid_inst),
        .i_pc    (w_ifid_pc),
        .o_valid (if_id_valid),
        .o_inst  (if_id_inst),
        .o_pc    (if_id_pc)
    );

    assign imem_addr = r_pc;

endmodule
